// File: rtl/alu_rr_arbiter_pkg.sv
package alu_rr_arbiter_pkg;

  localparam int unsigned NUM_REQ = 2;

  typedef enum logic [1:0] {
    ADD = 2'b00,
    SUB = 2'b01,
    AND = 2'b10,
    OR  = 2'b11
  } OP_t;

  typedef enum logic [1:0] {
    No_Shift    = 2'b00,
    Shift_Right = 2'b01,
    Shift_Left  = 2'b10
  } SH_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    RESP = 2'b10
  } ARB_t;

endpackage

// File: rtl/alu_rr_arbiter_alu_core.sv
module alu_core
  import alu_rr_arbiter_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  OP_t              op,
  input  logic [1:0]       sh,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             carry
);

  logic [WIDTH-1:0] a_sh;
  logic [WIDTH:0]   sum;

  always_comb begin
    a_sh = a;
    case (sh)
      Shift_Right: a_sh = {1'b0, a[WIDTH-1:1]};
      Shift_Left:  a_sh = {a[WIDTH-2:0], 1'b0};
      default:     a_sh = a;
    endcase
  end

  // SUB reports borrow, i.e. the inverted carry-out of A' + ~B + 1.
  always_comb begin
    sum    = '0;
    result = '0;
    carry  = 1'b0;
    case (op)
      ADD: begin
        sum    = {1'b0, a_sh} + {1'b0, b};
        result = sum[WIDTH-1:0];
        carry  = sum[WIDTH];
      end
      SUB: begin
        sum    = {1'b0, a_sh} + {1'b0, ~b} + (WIDTH+1)'(1);
        result = sum[WIDTH-1:0];
        carry  = ~sum[WIDTH];
      end
      AND:     result = a_sh & b;
      OR:      result = a_sh | b;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/alu_rr_arbiter.sv
module alu_rr_arbiter
  import alu_rr_arbiter_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_REQ-1:0]              req_valid,
  output logic [NUM_REQ-1:0]              req_ready,
  input  logic [NUM_REQ-1:0][1:0]         req_op,
  input  logic [NUM_REQ-1:0][1:0]         req_sh,
  input  logic [NUM_REQ-1:0][WIDTH-1:0]   req_a,
  input  logic [NUM_REQ-1:0][WIDTH-1:0]   req_b,
  output logic                            rsp_valid,
  input  logic                            rsp_ready,
  output logic                            rsp_id,
  output logic [WIDTH-1:0]                rsp_data,
  output logic                            rsp_carry,
  output logic                            busy
);

  ARB_t             state;
  logic             rr_ptr;
  OP_t              op_q;
  logic [1:0]       sh_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             id_q;
  logic             grant_vld;
  logic             grant_id;
  logic [WIDTH-1:0] alu_result;
  logic             alu_carry;

  always_comb begin
    grant_vld = 1'b0;
    grant_id  = 1'b0;
    if (!rst && state == IDLE) begin
      if (&req_valid) begin
        grant_vld = 1'b1;
        grant_id  = rr_ptr;
      end else if (req_valid[0]) begin
        grant_vld = 1'b1;
        grant_id  = 1'b0;
      end else if (req_valid[1]) begin
        grant_vld = 1'b1;
        grant_id  = 1'b1;
      end
    end
    req_ready = '0;
    if (grant_vld) req_ready[grant_id] = 1'b1;
  end

  alu_core #(.WIDTH(WIDTH)) u_alu (
    .op     (op_q),
    .sh     (sh_q),
    .a      (a_q),
    .b      (b_q),
    .result (alu_result),
    .carry  (alu_carry)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      rr_ptr    <= 1'b0;
      op_q      <= ADD;
      sh_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      id_q      <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_id    <= 1'b0;
      rsp_data  <= '0;
      rsp_carry <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_vld) begin
            op_q  <= OP_t'(req_op[grant_id]);
            sh_q  <= req_sh[grant_id];
            a_q   <= req_a[grant_id];
            b_q   <= req_b[grant_id];
            id_q  <= grant_id;
            busy  <= 1'b1;
            state <= EXEC;
          end
        end
        EXEC: begin
          rsp_data  <= alu_result;
          rsp_carry <= alu_carry;
          rsp_id    <= id_q;
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
            rr_ptr    <= ~id_q;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/alu_rr_arbiter.md
Name: alu_rr_arbiter

Overview:
- Shares one ALU (ops from `OP_t`: ADD/SUB/AND/OR; A pre-shift from `SH_t`) between two requesters.
- Each requester uses a valid/ready request channel. All requesters share one tagged valid/ready response channel.
- Round-robin grant; one operation in flight at a time; registered result.
- Sits between the top-level control logic and the shared ALU datapath.

Parameters:
- WIDTH, 8, operand and result width in bits (≥2).

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  2  per-requester request valid (bit i = requester i)
- req_ready  out  2  per-requester accept; at most one bit high
- req_op  in  2x2  per-requester `OP_t`
- req_sh  in  2x2  per-requester `SH_t` applied to A
- req_a  in  2xWIDTH  per-requester operand A
- req_b  in  2xWIDTH  per-requester operand B
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response consumer ready
- rsp_id  out  1  requester index the response belongs to
- rsp_data  out  WIDTH  ALU result
- rsp_carry  out  1  ADD carry-out / SUB borrow; 0 for AND/OR
- busy  out  1  high in EXEC or RESP

Behaviour:
- Reset (rst high at an edge): state=IDLE, rr_ptr=0, rsp_valid=0, rsp_id=0, rsp_data=0, rsp_carry=0, busy=0. While rst is high, req_ready=0.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - Grant selection: if both valid, grant requester rr_ptr; if only one valid, grant it; if none, stay in IDLE.
  - req_ready[g] is asserted combinationally in the same cycle. It may depend on req_valid.
  - At the edge, latch op/sh/a/b/id of the granted requester and go to EXEC.
- EXEC: compute through alu_core and register rsp_data/rsp_carry/rsp_id at the edge; go to RESP.
- RESP:
  - rsp_valid=1. rsp_data/rsp_id/rsp_carry are held stable until rsp_valid && rsp_ready.
  - On that handshake edge: rr_ptr = ~granted id, state=IDLE.
- Latency: request accepted in cycle T; rsp_valid high from cycle T+2. Earliest next accept is T+3 (when rsp_ready is high in T+2).
- req_ready is 0 in EXEC and RESP. Requesters hold valid and payload stable until ready.
- Shift:
  - No_Shift: A unchanged.
  - Shift_Right: logical right shift by 1, 0 into MSB.
  - Shift_Left: logical left shift by 1, 0 into LSB; bit shifted out is discarded.
  - Code 2'b11 is treated as No_Shift.
- Arithmetic:
  - ADD: WIDTH-bit result wraps modulo 2^WIDTH; carry = bit WIDTH of the sum.
  - SUB: computed as A'+~B+1; result wraps; rsp_carry = 1 when A' < B unsigned (borrow).
- rr_ptr changes only on a completed response handshake. Requester idle cycles do not move it.
- Reset in EXEC or RESP: the in-flight operation is discarded, no response is ever issued for it, and the state returns to IDLE with rr_ptr=0.
- A requester dropping valid before ready violates protocol; behaviour is undefined and not checked.

Decomposition:
- Shared package (Decoders): reuse `OP_t` and `SH_t`.
- Add to the same package:
  - `ARB_t` enum {IDLE=2'b00, EXEC=2'b01, RESP=2'b10}
  - constant `NUM_REQ=2`
- Sub-module alu_core: combinational, inputs (op, sh, a, b), outputs (result, carry), parameter WIDTH. The arbiter instantiates exactly one.

Test Plan:
- Basic ADD: rst 2 cycles, then req_valid=2'b01, op=ADD, sh=No_Shift, a=8'h05, b=8'h03 → req_ready=2'b01 same cycle; rsp_valid 2 cycles later with rsp_data=8'h08, carry=0, id=0.
- SUB with borrow: req1 SUB a=8'h03, b=8'h05 → rsp_data=8'hFE, rsp_carry=1, rsp_id=1.
- Shift then op:
  - req0 Shift_Left a=8'h81 ADD b=8'h00 → 8'h02, carry=0.
  - req0 Shift_Right a=8'h81 OR b=8'h10 → 8'h50.
  - sh=2'b11 a=8'h81 AND b=8'hFF → 8'h81.
- Fairness: both valid continuously, rsp_ready=1 → grant/id sequence 0,1,0,1. Each accept is exactly 3 cycles apart, and req_ready is never 2'b11.
- Backpressure: rsp_ready=0 for 5 cycles in RESP → rsp_valid, data, id and carry stay constant, req_ready=0 throughout, busy=1. After rsp_ready rises, the handshake completes and IDLE follows.
- Reset mid-op: assert rst in the EXEC cycle of an ADD → no rsp_valid afterwards. With both valid after reset, requester 0 is granted first.
